// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache controller: bus command encoding,
// geometry constants and the address-split helpers used by the top and the
// write buffer.
package dcache_ctrl_pkg;

  localparam int DC_LINES     = 32;
  localparam int DC_IDX       = $clog2(DC_LINES);
  localparam int WB_DEPTH     = 4;
  localparam int NUM_MEM_TAGS = 15;
  localparam int LTAG_W       = 64 - 3 - DC_IDX;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  function automatic logic [DC_IDX-1:0] addr_idx(input logic [63:0] addr);
    return addr[3+DC_IDX-1:3];
  endfunction

  function automatic logic [LTAG_W-1:0] addr_ltag(input logic [63:0] addr);
    return addr[63:3+DC_IDX];
  endfunction

endpackage

// File: rtl/dcache_ctrl_wbuf.sv
// dc_wbuf: circular store buffer between the cache and the memory bus.
// Stores are pushed at the tail and drained from the head; a load can look
// up the buffer and gets the data of the youngest entry with a matching
// 8-byte word address.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push_i/_addr/_data  enqueue a store (word address = byte addr[63:3])
//   pop_i               drop the head entry (caller guarantees non-empty)
//   lookup_addr_i       word address to search for
//   empty_o, full_o     occupancy flags (full_o is registered)
//   head_addr_o/_data_o oldest entry, driven onto the bus while draining
//   match_o/_data_o     youngest matching entry
module dc_wbuf
  import dcache_ctrl_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [60:0] push_addr_i,
  input  logic [63:0] push_data_i,
  input  logic        pop_i,
  input  logic [60:0] lookup_addr_i,
  output logic        empty_o,
  output logic        full_o,
  output logic [60:0] head_addr_o,
  output logic [63:0] head_data_o,
  output logic        match_o,
  output logic [63:0] match_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [60:0]   addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q;
  logic [PW-1:0] pos;

  always_comb begin
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_i);
    count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end

  // Walk oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    match_o      = 1'b0;
    match_data_o = '0;
    pos          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[pos] == lookup_addr_i)) begin
        match_o      = 1'b1;
        match_data_o = data_q[pos];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  assign empty_o     = (count_q == '0);
  assign full_o      = full_q;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller between the LSQ head and the memory bus.
// Direct-mapped, write-through, no-write-allocate cache with 8-byte lines.
// Loads hit in the write buffer or the cache in the same cycle (tag 0);
// misses are forwarded to memory and the accepted memory tag is handed back
// to the LSQ. Returning fill data is presented with its tag and installed
// unless a store to the same line arrived while the miss was outstanding.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   lsq2mem_command/_addr/_data        request from the LSQ head
//   mem2lsq_response                   memory tag accepted for a load miss
//   dcache2lsq_valid/_tag/_data        load data back to the LSQ
//   wb_full                            write buffer full (registered)
//   proc2mem_command/_addr/_data       memory bus request
//   mem2proc_response/_data/_tag       memory bus accept tag and fill return
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  lsq2mem_command,
  input  logic [63:0] lsq2mem_addr,
  input  logic [63:0] lsq2mem_data,
  output logic [3:0]  mem2lsq_response,
  output logic        dcache2lsq_valid,
  output logic [3:0]  dcache2lsq_tag,
  output logic [63:0] dcache2lsq_data,
  output logic        wb_full,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  logic [DC_LINES-1:0] line_valid_q;
  logic [LTAG_W-1:0]   line_tag_q  [DC_LINES];
  logic [63:0]         line_data_q [DC_LINES];

  logic [NUM_MEM_TAGS:0] pend_valid_q, pend_valid_d;
  logic [NUM_MEM_TAGS:0] pend_install_q, pend_install_d;
  logic [DC_IDX-1:0]     pend_idx_q  [NUM_MEM_TAGS+1];
  logic [LTAG_W-1:0]     pend_ltag_q [NUM_MEM_TAGS+1];

  logic [DC_IDX-1:0] req_idx;
  logic [LTAG_W-1:0] req_ltag;
  logic              is_load, is_store, cache_hit;
  logic              fill_hit, fill_install, load_miss, miss_accept;

  logic        wb_empty, wb_match, wb_pop;
  logic [60:0] wb_head_addr;
  logic [63:0] wb_head_data, wb_match_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^lsq2mem_addr[2:0];

  assign req_idx   = addr_idx(lsq2mem_addr);
  assign req_ltag  = addr_ltag(lsq2mem_addr);
  assign is_load   = !reset && (lsq2mem_command == BUS_LOAD);
  assign is_store  = !reset && (lsq2mem_command == BUS_STORE);
  assign cache_hit = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_ltag);
  assign fill_hit  = !reset && (mem2proc_tag != '0) && pend_valid_q[mem2proc_tag];

  // A store to the line being filled in this same cycle wins: its data is
  // newer than anything memory is returning.
  assign fill_install = fill_hit && pend_install_q[mem2proc_tag] &&
                        !(is_store && (pend_idx_q[mem2proc_tag] == req_idx));

  assign miss_accept = load_miss && (mem2proc_response != '0);

  dc_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (is_store),
    .push_addr_i  (lsq2mem_addr[63:3]),
    .push_data_i  (lsq2mem_data),
    .pop_i        (wb_pop),
    .lookup_addr_i(lsq2mem_addr[63:3]),
    .empty_o      (wb_empty),
    .full_o       (wb_full),
    .head_addr_o  (wb_head_addr),
    .head_data_o  (wb_head_data),
    .match_o      (wb_match),
    .match_data_o (wb_match_data)
  );

  always_comb begin
    mem2lsq_response = '0;
    dcache2lsq_valid = 1'b0;
    dcache2lsq_tag   = '0;
    dcache2lsq_data  = '0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    load_miss        = 1'b0;
    wb_pop           = 1'b0;
    if (!reset) begin
      if (fill_hit) begin
        dcache2lsq_valid = 1'b1;
        dcache2lsq_tag   = mem2proc_tag;
        dcache2lsq_data  = mem2proc_data;
      end else if (is_load) begin
        if (wb_match) begin
          dcache2lsq_valid = 1'b1;
          dcache2lsq_data  = wb_match_data;
        end else if (cache_hit) begin
          dcache2lsq_valid = 1'b1;
          dcache2lsq_data  = line_data_q[req_idx];
        end else begin
          load_miss        = 1'b1;
          proc2mem_command = BUS_LOAD;
          proc2mem_addr    = {lsq2mem_addr[63:3], 3'b000};
          mem2lsq_response = mem2proc_response;
        end
      end
      if (!load_miss && !wb_empty) begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = {wb_head_addr, 3'b000};
        proc2mem_data    = wb_head_data;
        wb_pop           = (mem2proc_response != '0);
      end
    end
  end

  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_install_d = pend_install_q;
    if (fill_hit) pend_valid_d[mem2proc_tag] = 1'b0;
    if (miss_accept) begin
      pend_valid_d[mem2proc_response]   = 1'b1;
      pend_install_d[mem2proc_response] = 1'b1;
    end
    // Outstanding misses to a line just written would bring back stale data.
    if (is_store) begin
      for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
        if (pend_idx_q[t] == req_idx) pend_install_d[t] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_q   <= '0;
      pend_valid_q   <= '0;
      pend_install_q <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_install_q <= pend_install_d;
      if (fill_install) line_valid_q[pend_idx_q[mem2proc_tag]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (miss_accept) begin
      pend_idx_q[mem2proc_response]  <= req_idx;
      pend_ltag_q[mem2proc_response] <= req_ltag;
    end
    if (fill_install) begin
      line_tag_q[pend_idx_q[mem2proc_tag]]  <= pend_ltag_q[mem2proc_tag];
      line_data_q[pend_idx_q[mem2proc_tag]] <= mem2proc_data;
    end
    if (is_store && cache_hit) line_data_q[req_idx] <= lsq2mem_data;
  end

endmodule
